sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 16, setting the accumulator width in bits; legal values are 10 or more.
REQ-002 The block SHALL have parameter COUNT_N, default 4, setting the number of sums per block; legal range is 1 to 255.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset; it SHALL be synchronous and active-low.
REQ-005 Port sum_valid, input, 1 bit: an adder result is present on sum.
REQ-006 Port sum, input, 9 bits: unsigned adder result, range 0..510.
REQ-007 Port sum_ready, output, 1 bit: the block accepts sum this cycle.
REQ-008 Port clear, input, 1 bit: synchronous discard of the block in progress.
REQ-009 Port acc_valid, output, 1 bit: a completed block result is held on acc_data.
REQ-010 Port acc_data, output, ACC_W bits: the block result.
REQ-011 Port acc_sat, output, 1 bit: saturation occurred within the held block.
REQ-012 Port acc_ready, input, 1 bit: the consumer takes the result.
REQ-013 Port blk_cnt, output, 8 bits: count of completed result handshakes, wrapping.

Function
REQ-014 The FSM SHALL have two states, ACCUM and HOLD.
REQ-015 sum_ready SHALL equal (state==ACCUM) and not clear; this is a combinational output.
REQ-016 A sum is accepted on a rising edge where sum_valid and sum_ready are both 1.
REQ-017 On each accept, the accumulator SHALL be set to acc + zero-extended sum, saturating at 2^ACC_W-1.
REQ-018 On saturation, the sticky sat flag SHALL be set; it clears only at result handshake, clear or reset.
REQ-019 On each accept, the sample counter SHALL increment.
REQ-020 The accept that brings the sample count to COUNT_N SHALL move the FSM to HOLD on that edge, so acc_valid=1 in the next cycle (1-cycle latency from last accept).
REQ-021 In ACCUM, acc_valid SHALL be 0.
REQ-022 In HOLD, acc_valid SHALL be 1, and acc_data and acc_sat SHALL equal the accumulator and sat flag.
REQ-023 acc_data and acc_sat SHALL read 0 whenever acc_valid=0.
REQ-024 In HOLD, acc_data and acc_sat SHALL stay stable while acc_ready=0, with no upper limit on stall length.
REQ-025 A result handshake occurs on an edge where acc_valid and acc_ready are both 1; it SHALL zero the accumulator, counter and sat flag, increment blk_cnt (255 wraps to 0), and return the FSM to ACCUM.
REQ-026 No sum SHALL be accepted on the handshake edge; the earliest next accept is the following cycle.
REQ-027 clear=1 SHALL take priority over every other event, in either state: on that edge the accumulator, counter and sat flag SHALL be zeroed, the FSM SHALL go to ACCUM, and any HOLD result SHALL be discarded.
REQ-028 clear SHALL leave blk_cnt unchanged.
REQ-029 A sum presented while clear=1 is not accepted, because sum_ready=0.
REQ-030 If clear and acc_ready are both 1 in HOLD, no handshake SHALL be counted.
REQ-031 With COUNT_N=1, every accepted sum SHALL produce its own result.
REQ-032 acc_ready in ACCUM and sum_valid in HOLD SHALL be ignored.

Reset
REQ-033 While rst_n=0 at a rising edge, the block SHALL enter state ACCUM.
REQ-034 On that reset edge, the accumulator, sample counter, sat flag and blk_cnt SHALL be set to 0.
REQ-035 After that reset edge, the outputs SHALL read acc_valid=0, acc_data=0, acc_sat=0 and blk_cnt=0.
REQ-036 While rst_n=0, sum_ready SHALL be 1; since reset is synchronous, no accept takes effect on a reset edge.
REQ-037 Reset SHALL take priority over clear and over both handshakes.
REQ-038 Reset asserted in HOLD SHALL discard the held result.

Verification
REQ-039 Basic block (defaults): sums 10, 20, 30, 40 on consecutive cycles with acc_ready=1 -> acc_valid=1 exactly 1 cycle after the 4th accept, acc_data=100, acc_sat=0, blk_cnt=1 after the handshake.
REQ-040 Saturation (ACC_W=10, COUNT_N=3): sums 510, 510, 510 -> acc_data=1023, acc_sat=1; the next block of 1, 1, 1 -> acc_data=3, acc_sat=0.
REQ-041 Backpressure: hold acc_ready=0 for 6 cycles in HOLD -> acc_data is stable, sum_ready=0, and no sum is accepted; raise acc_ready -> one handshake, then sum_ready=1 the next cycle.
REQ-042 Clear mid-block: accept 7 and 9, then pulse clear together with sum_valid (sum=5) -> 5 not accepted; a following block of 1, 2, 3, 4 -> acc_data=10 and blk_cnt unchanged by the clear.
REQ-043 Reset in HOLD with acc_data=100 -> next cycle acc_valid=0, acc_data=0, blk_cnt=0, sum_ready=1.
REQ-044 Wrap: complete 256 blocks -> blk_cnt reads 0; COUNT_N=1 with sum 510 -> acc_data=510 on each block.

Source files
------------

// File: rtl/sum_accumulator.sv
// sum_accumulator: adds up COUNT_N unsigned adder results per block with a
// saturating accumulator, then holds the block result until the consumer
// takes it. A sticky flag reports whether any add in the block saturated.
// clear drops the block in progress. blk_cnt counts completed handshakes.
module sum_accumulator #(
  parameter int ACC_W   = 16,
  parameter int COUNT_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sum_valid,
  input  logic [8:0]       sum,
  output logic             sum_ready,
  input  logic             clear,
  output logic             acc_valid,
  output logic [ACC_W-1:0] acc_data,
  output logic             acc_sat,
  input  logic             acc_ready,
  output logic [7:0]       blk_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Sample count reached on the accept that completes a block.
  localparam logic [7:0] LAST_CNT = 8'(COUNT_N - 1);

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [7:0]       cnt_r;
  logic             sat_r;
  logic [7:0]       blk_cnt_r;
  logic             acc_valid_r;
  logic [ACC_W-1:0] acc_data_r;
  logic             acc_sat_r;

  logic             accept_s;
  logic [ACC_W:0]   wide_s;
  logic             ovf_s;
  logic [ACC_W-1:0] acc_next_s;
  logic             sat_next_s;
  logic             last_s;

  // Ready is forced high during reset; the reset branch below still wins,
  // so nothing is accepted on a reset edge.
  assign sum_ready = !rst_n || ((state_r == ACCUM) && !clear);

  // Next accumulator value: one extra bit catches the carry out, which
  // means the true sum no longer fits and the result pins at all ones.
  always_comb begin
    accept_s   = sum_valid && (state_r == ACCUM) && !clear;
    wide_s     = {1'b0, acc_r} + {{(ACC_W - 8){1'b0}}, sum};
    ovf_s      = wide_s[ACC_W];
    if (ovf_s) begin
      acc_next_s = {ACC_W{1'b1}};
    end else begin
      acc_next_s = wide_s[ACC_W-1:0];
    end
    sat_next_s = sat_r || ovf_s;
    last_s     = (cnt_r == LAST_CNT);
  end

  // Block FSM with registered result outputs. Priority: reset, then clear,
  // then the handshake or accept of the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ACCUM;
      acc_r       <= '0;
      cnt_r       <= 8'd0;
      sat_r       <= 1'b0;
      blk_cnt_r   <= 8'd0;
      acc_valid_r <= 1'b0;
      acc_data_r  <= '0;
      acc_sat_r   <= 1'b0;
    end else if (clear) begin
      state_r     <= ACCUM;
      acc_r       <= '0;
      cnt_r       <= 8'd0;
      sat_r       <= 1'b0;
      acc_valid_r <= 1'b0;
      acc_data_r  <= '0;
      acc_sat_r   <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            acc_r <= acc_next_s;
            sat_r <= sat_next_s;
            cnt_r <= cnt_r + 8'd1;
            if (last_s) begin
              state_r     <= HOLD;
              acc_valid_r <= 1'b1;
              acc_data_r  <= acc_next_s;
              acc_sat_r   <= sat_next_s;
            end else begin
              state_r     <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state_r     <= ACCUM;
            acc_r       <= '0;
            cnt_r       <= 8'd0;
            sat_r       <= 1'b0;
            blk_cnt_r   <= blk_cnt_r + 8'd1;
            acc_valid_r <= 1'b0;
            acc_data_r  <= '0;
            acc_sat_r   <= 1'b0;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r     <= ACCUM;
          acc_r       <= '0;
          cnt_r       <= 8'd0;
          sat_r       <= 1'b0;
          acc_valid_r <= 1'b0;
          acc_data_r  <= '0;
          acc_sat_r   <= 1'b0;
        end
      endcase
    end
  end

  assign acc_valid = acc_valid_r;
  assign acc_data  = acc_data_r;
  assign acc_sat   = acc_sat_r;
  assign blk_cnt   = blk_cnt_r;

endmodule

// File: tb/tb_sum_accumulator.sv
// Testbench for sum_accumulator: three configurations (16/4, 10/3, 10/1)
// each with a block-level reference model, directed scenarios with literal
// expectations, then a randomized phase checked every cycle.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sv [3];
  logic [8:0] sm [3];
  logic       cl [3];
  logic       ar [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int AW   = (g == 0) ? 16 : 10;
    localparam int CN   = (g == 0) ? 4 : ((g == 1) ? 3 : 1);
    localparam int MAXV = (1 << AW) - 1;

    logic          sum_ready;
    logic          acc_valid;
    logic [AW-1:0] acc_data;
    logic          acc_sat;
    logic [7:0]    blk_cnt;

    sum_accumulator #(.ACC_W(AW), .COUNT_N(CN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sum_valid (sv[g]),
      .sum       (sm[g]),
      .sum_ready (sum_ready),
      .clear     (cl[g]),
      .acc_valid (acc_valid),
      .acc_data  (acc_data),
      .acc_sat   (acc_sat),
      .acc_ready (ar[g]),
      .blk_cnt   (blk_cnt)
    );

    // Model: exact (unbounded) running total and sample count of the block;
    // the saturated result and flag are derived from the exact total.
    int m_tot     = 0;
    int m_n       = 0;
    bit m_hold    = 1'b0;
    int m_blk     = 0;
    bit m_started = 1'b0;

    // Model update on each rising edge from the inputs presented that cycle.
    always @(posedge clk) begin
      if (!rst_n) begin
        m_tot <= 0; m_n <= 0; m_hold <= 1'b0; m_blk <= 0; m_started <= 1'b1;
      end else if (cl[g]) begin
        m_tot <= 0; m_n <= 0; m_hold <= 1'b0;
      end else if (m_hold) begin
        if (ar[g]) begin
          m_tot <= 0; m_n <= 0; m_hold <= 1'b0; m_blk <= (m_blk + 1) % 256;
        end
      end else if (sv[g]) begin
        m_tot  <= m_tot + int'(sm[g]);
        m_n    <= m_n + 1;
        m_hold <= ((m_n + 1) == CN);
      end
    end

    // Compare all outputs against the model mid-cycle.
    always @(negedge clk) begin
      if (m_started) begin
        chk($sformatf("cfg%0d sum_ready", g), int'(sum_ready),
            int'(!rst_n || (!m_hold && !cl[g])));
        chk($sformatf("cfg%0d acc_valid", g), int'(acc_valid), int'(m_hold));
        chk($sformatf("cfg%0d acc_data", g), int'(acc_data),
            m_hold ? ((m_tot > MAXV) ? MAXV : m_tot) : 0);
        chk($sformatf("cfg%0d acc_sat", g), int'(acc_sat),
            int'(m_hold && (m_tot > MAXV)));
        chk($sformatf("cfg%0d blk_cnt", g), int'(blk_cnt), m_blk);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input int s);
    sv[i] = 1'b1;
    sm[i] = 9'(s);
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sv[i] = 1'b0; sm[i] = 9'd0; cl[i] = 1'b0; ar[i] = 1'b0;
    end
    #1;
    repeat (3) cyc();
    rst_n = 1'b1;
    #1;
    chk("reset acc_valid", int'(cfg[0].acc_valid), 0);
    chk("reset acc_data", int'(cfg[0].acc_data), 0);
    chk("reset acc_sat", int'(cfg[0].acc_sat), 0);
    chk("reset blk_cnt", int'(cfg[0].blk_cnt), 0);
    chk("reset sum_ready", int'(cfg[0].sum_ready), 1);

    // Basic block 10+20+30+40 with consumer always ready.
    ar[0] = 1'b1;
    send(0, 10); send(0, 20); send(0, 30);
    chk("basic not early", int'(cfg[0].acc_valid), 0);
    send(0, 40);
    sv[0] = 1'b0;
    chk("basic acc_valid", int'(cfg[0].acc_valid), 1);
    chk("basic acc_data", int'(cfg[0].acc_data), 100);
    chk("basic acc_sat", int'(cfg[0].acc_sat), 0);
    cyc();
    chk("basic blk_cnt", int'(cfg[0].blk_cnt), 1);
    chk("basic released", int'(cfg[0].acc_valid), 0);

    // Backpressure: six stalled cycles with a sum pending, then release.
    ar[0] = 1'b0;
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    sv[0] = 1'b1; sm[0] = 9'd99;
    for (int k = 0; k < 6; k++) begin
      chk("stall acc_data", int'(cfg[0].acc_data), 10);
      chk("stall sum_ready", int'(cfg[0].sum_ready), 0);
      cyc();
    end
    ar[0] = 1'b1;
    cyc();
    sv[0] = 1'b0;
    #1;
    chk("release acc_valid", int'(cfg[0].acc_valid), 0);
    chk("release sum_ready", int'(cfg[0].sum_ready), 1);
    chk("release blk_cnt", int'(cfg[0].blk_cnt), 2);

    // Clear mid-block with a colliding sum, then a fresh block.
    send(0, 7); send(0, 9);
    cl[0] = 1'b1; sv[0] = 1'b1; sm[0] = 9'd5;
    #1;
    chk("clear sum_ready", int'(cfg[0].sum_ready), 0);
    cyc();
    cl[0] = 1'b0;
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    sv[0] = 1'b0;
    chk("after clear acc_data", int'(cfg[0].acc_data), 10);
    chk("clear keeps blk_cnt", int'(cfg[0].blk_cnt), 2);
    cyc();
    chk("after clear blk_cnt", int'(cfg[0].blk_cnt), 3);

    // Saturation on the 10-bit, 3-sample configuration.
    ar[1] = 1'b1;
    send(1, 510); send(1, 510); send(1, 510);
    sv[1] = 1'b0;
    chk("sat acc_data", int'(cfg[1].acc_data), 1023);
    chk("sat acc_sat", int'(cfg[1].acc_sat), 1);
    cyc();
    send(1, 1); send(1, 1); send(1, 1);
    sv[1] = 1'b0;
    chk("post-sat acc_data", int'(cfg[1].acc_data), 3);
    chk("post-sat acc_sat", int'(cfg[1].acc_sat), 0);
    cyc();

    // Single-sample blocks: 256 handshakes wrap blk_cnt back to 0.
    ar[2] = 1'b1;
    for (int b = 0; b < 256; b++) begin
      send(2, 510);
      chk("n1 acc_data", int'(cfg[2].acc_data), 510);
      cyc();
      chk("n1 blk_cnt", int'(cfg[2].blk_cnt), (b + 1) % 256);
    end
    sv[2] = 1'b0;
    chk("wrap blk_cnt", int'(cfg[2].blk_cnt), 0);

    // Reset while holding a result.
    ar[0] = 1'b0;
    send(0, 10); send(0, 20); send(0, 30); send(0, 40);
    sv[0] = 1'b0;
    chk("pre-reset acc_data", int'(cfg[0].acc_data), 100);
    rst_n = 1'b0;
    #1;
    chk("in-reset sum_ready", int'(cfg[0].sum_ready), 1);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("reset-hold acc_valid", int'(cfg[0].acc_valid), 0);
    chk("reset-hold acc_data", int'(cfg[0].acc_data), 0);
    chk("reset-hold blk_cnt", int'(cfg[0].blk_cnt), 0);
    chk("reset-hold sum_ready", int'(cfg[0].sum_ready), 1);

    // Randomized traffic on all three configurations.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 3; i++) begin
        sv[i] = ($urandom_range(0, 3) != 0);
        sm[i] = ($urandom_range(0, 7) == 0) ? 9'd510 : 9'($urandom_range(0, 510));
        cl[i] = ($urandom_range(0, 29) == 0);
        ar[i] = ($urandom_range(0, 9) < 6);
      end
      rst_n = ($urandom_range(0, 299) != 0);
      cyc();
    end
    rst_n = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
